// File: rtl/rr_lock_arbiter.sv
// Round-robin bus arbiter with multi-cycle grant hold, owner lock and a hold timeout.
// Within each search window the highest requesting index wins.
module rr_lock_arbiter #(
   parameter int WIDTH    = 8,
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = $clog2(HOLD_MAX + 1)
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [WIDTH-1:0]         request_i,
   input  logic [WIDTH-1:0]         lock_i,
   input  logic                     done_i,
   output logic [WIDTH-1:0]         grant_o,
   output logic [$clog2(WIDTH)-1:0] grant_id_o,
   output logic                     grant_valid_o,
   output logic                     timeout_o
);

   localparam int IDW = $clog2(WIDTH);
   // A disabled timeout would give a zero-width counter; keep at least one bit.
   localparam int CW  = (CNT_W < 1) ? 1 : CNT_W;
   localparam logic [CW-1:0]    CNT_LAST = (HOLD_MAX == 0) ? '1 : CW'(HOLD_MAX - 1);
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] grant_q, grant_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             tmo_q, tmo_d;

   logic             owner_req;
   logic             owner_lock;
   logic             tmo;
   logic             rel;
   logic [WIDTH-1:0] others;
   logic [IDW-1:0]   win;

   // Search below the last owner first, then wrap to the highest requester.
   function automatic logic [IDW-1:0] pick(input logic [WIDTH-1:0] req,
                                           input logic [IDW-1:0]   last);
      logic [WIDTH-1:0] masked;
      logic [IDW-1:0]   hi_m;
      logic [IDW-1:0]   hi_r;
      masked = '0;
      hi_m   = '0;
      hi_r   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i < int'(last)) masked[i] = req[i];
      end
      for (int i = 0; i < WIDTH; i++) begin
         if (masked[i]) hi_m = IDW'(i);
         if (req[i])    hi_r = IDW'(i);
      end
      return (|masked) ? hi_m : hi_r;
   endfunction

   always_comb begin
      owner_req  = request_i[ptr_q];
      owner_lock = lock_i[ptr_q];
      others     = request_i & ~(ONE << ptr_q);
      tmo        = (HOLD_MAX != 0) && (cnt_q == CNT_LAST);
      rel        = (done_i & ~owner_lock) | ~owner_req | tmo;
      win        = '0;

      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      tmo_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (|request_i) begin
               win     = pick(request_i, ptr_q);
               grant_d = ONE << win;
               ptr_d   = win;
               cnt_d   = '0;
               valid_d = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (!rel) begin
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end else begin
               tmo_d = tmo;
               // The owner is never a candidate here, so a timed-out owner is skipped.
               if (|others) begin
                  win     = pick(others, ptr_q);
                  grant_d = ONE << win;
                  ptr_d   = win;
                  cnt_d   = '0;
               end else if (owner_req && !tmo) begin
                  cnt_d = '0;
               end else begin
                  grant_d = '0;
                  valid_d = 1'b0;
                  cnt_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         tmo_q   <= tmo_d;
      end
   end

   assign grant_o       = grant_q;
   assign grant_id_o    = ptr_q;
   assign grant_valid_o = valid_q;
   assign timeout_o     = tmo_q;

endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Registered round-robin arbiter that shares one bus or functional unit among WIDTH requesters.
- Holds a grant across multi-cycle transfers and supports requester lock for atomic sequences.
- Enforces a hold timeout so no requester can starve the others.
- Winner selection inside each search mask reuses the team's fixed-priority rule: highest index wins. It sits between requester ports and the shared resource's mux select.

Parameters:
- WIDTH, 8, number of requesters; power of two, at least 2.
- HOLD_MAX, 16, maximum cycles one grant may be held; 0 disables the timeout.
- CNT_W, $clog2(HOLD_MAX+1), hold counter width; derived, do not override.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- request_i  input  WIDTH  per-requester request level; held high until served.
- lock_i  input  WIDTH  per-requester lock; owner keeps the grant across done_i while its lock bit is high.
- done_i  input  1  current owner's transfer completes this cycle.
- grant_o  output  WIDTH  registered one-hot grant; all zero when idle.
- grant_id_o  output  $clog2(WIDTH)  binary index of the current owner; valid when grant_valid_o is high.
- grant_valid_o  output  1  a grant is active (equals |grant_o).
- timeout_o  output  1  one-cycle pulse when a grant is force-released by the hold timeout.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream): grant_o=0, grant_id_o=0, grant_valid_o=0, timeout_o=0, state=IDLE, last pointer=0, hold counter=0.
- Reset mid-grant drops the grant immediately with no done handshake; the next grant after reset follows the rule for the first grant.
- Winner function, combinational from request_i and last pointer L:
  - masked = request_i with bits at index >= L cleared.
  - If masked != 0, winner = highest set index of masked; otherwise winner = highest set index of request_i.
  - After reset (L=0) the highest requesting index wins first.
- States:
  - IDLE: if request_i != 0, next edge grant_o = onehot(winner), grant_id_o = winner, L = winner, counter = 0, go BUSY. Latency from request to grant is 1 cycle. Otherwise stay IDLE.
  - BUSY: release = (done_i & ~lock_i[owner]) | ~request_i[owner] | tmo. tmo = (HOLD_MAX != 0) & (counter == HOLD_MAX-1).
  - BUSY without release: counter increments, saturating; grant unchanged.
  - BUSY with release and no other bit of request_i set, with the owner's request low or the owner being the only requester: if the owner's request is still high and the release is not a timeout, regrant the owner; otherwise grant_o = 0 and go IDLE.
  - BUSY with release and other requests pending: winner is computed from the current request_i with L = owner. The next edge loads the new grant directly with no idle bubble, counter = 0, L = new winner.
- Timeout:
  - On a tmo release, timeout_o = 1 for exactly the next cycle.
  - The timed-out owner is excluded from the immediate re-arbitration even if its request is still high. If it is the only requester, go IDLE for one cycle, then regrant it.
- Lock:
  - done_i with the owner's lock high keeps the grant and does not reset the counter, so the timeout still bounds locked sequences.
  - lock_i bits of non-owners are ignored.
- done_i while in IDLE is ignored.
- The owner dropping its request releases the grant regardless of done_i or lock_i.
- grant_o is always one-hot or zero. It only changes on the cycle after a release or an IDLE arbitration.

Test Plan:
- Reset, then request_i=8'b1001_0010 held → cycle+1 grant_o=8'b1000_0000 (id 7). After done_i, grant moves to id 4, then id 1, then back to id 7, with no idle cycle between grants.
- Requests on 2 and 5 only, done_i every 3rd cycle → grants alternate 5,2,5,2, each held exactly 3 cycles; grant_valid_o never drops.
- Owner 3 with lock_i[3]=1, done_i pulsed twice, request 6 pending → grant stays id 3. After lock_i[3]=0 and done_i, next cycle grant id 6.
- HOLD_MAX=16, owner 0 never asserts done_i, request 1 pending → release after 16 grant cycles, timeout_o high 1 cycle, grant id 1 next cycle. With only request 0 → one idle cycle, then regrant id 0.
- Owner 4 drops request_i[4] mid-transfer with no done_i → next cycle grant moves to the pending requester, or grant_o=0 if none pending.
- rst_n_i pulled low while BUSY → grant_o=0 asynchronously. After release, requests {0,7} → id 7 granted first.
